// File: rtl/noc_add_pe.sv
// Network-on-chip processing element: collects two tagged operand flits, adds or subtracts them,
// and sends the result as a fixed list of flits to the configured destinations.
module noc_add_pe #(
  parameter int unsigned                 DATA_W    = 64,
  parameter int unsigned                 DEST_W    = 4,
  parameter int unsigned                 NUM_DEST  = 3,
  parameter logic [NUM_DEST*DEST_W-1:0]  DEST_LIST = {4'd1, 4'd5, 4'd3},
  parameter logic [NUM_DEST-1:0]         VC_LIST   = 3'b110,
  parameter int unsigned                 MODE      = 0,
  localparam int unsigned                FLIT_W    = DATA_W + DEST_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  output logic              busy,
  output logic              carry_err,
  output logic              dup_err,
  output logic [15:0]       op_count
);

  localparam int unsigned       IDX_W    = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DEST - 1);

  typedef enum logic [1:0] {COLLECT, COMPUTE, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic              have_a, have_b;
  logic [IDX_W-1:0]  idx;
  logic              accept, load_a, load_b;
  logic [DATA_W:0]   wide_res;
  logic              unused_in;

  assign in_ready = (state == COLLECT);
  assign busy     = (state != COLLECT);
  assign accept   = in_valid & in_ready;
  assign load_a   = accept & in_flit[FLIT_W-1] & ~in_flit[DATA_W];
  assign load_b   = accept & in_flit[FLIT_W-1] & in_flit[DATA_W];

  // Incoming tail and dest fields carry no meaning for an operand.
  assign unused_in = ^in_flit[FLIT_W-2:DATA_W+1];

  // The extra top bit is the carry (add) or borrow (sub).
  assign wide_res = (MODE == 1) ? ({1'b0, op_a} - {1'b0, op_b})
                                : ({1'b0, op_a} + {1'b0, op_b});

  function automatic logic [FLIT_W-1:0] make_flit(input logic [IDX_W-1:0] i,
                                                  input logic [DATA_W-1:0] d);
    logic [NUM_DEST*DEST_W-1:0] dl;
    logic [NUM_DEST-1:0]        vl;
    dl = DEST_LIST >> (32'(i) * DEST_W);
    vl = VC_LIST >> i;
    return {1'b1, (i == LAST_IDX), dl[DEST_W-1:0], vl[0], d};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      have_a    <= 1'b0;
      have_b    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      carry_err <= 1'b0;
      dup_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (load_a) begin
            op_a   <= in_flit[DATA_W-1:0];
            have_a <= 1'b1;
            if (have_a) dup_err <= 1'b1;
          end
          if (load_b) begin
            op_b   <= in_flit[DATA_W-1:0];
            have_b <= 1'b1;
            if (have_b) dup_err <= 1'b1;
          end
          if ((have_a | load_a) & (have_b | load_b)) state <= COMPUTE;
        end
        COMPUTE: begin
          result <= wide_res[DATA_W-1:0];
          if (wide_res[DATA_W]) carry_err <= 1'b1;
          idx    <= '0;
          state  <= SEND;
        end
        SEND: begin
          // First SEND cycle loads the output register, giving the two-cycle result latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_flit  <= make_flit(idx, result);
          end else if (out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_flit  <= '0;
              have_a    <= 1'b0;
              have_b    <= 1'b0;
              idx       <= '0;
              op_count  <= op_count + 16'd1;
              state     <= COLLECT;
            end else begin
              idx      <= idx + 1'b1;
              out_flit <= make_flit(idx + 1'b1, result);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_add_pe.sv
// Directed bench for noc_add_pe: three instances (add, subtract, single destination) checked
// against a queue of expected output flits.
module tb_noc_add_pe;
  localparam int FW = 71;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n[3];
  logic          in_valid[3];
  logic [FW-1:0] in_flit[3];
  logic          in_ready[3];
  logic          out_valid[3];
  logic [FW-1:0] out_flit[3];
  logic          out_ready[3];
  logic          busy[3];
  logic          carry_err[3];
  logic          dup_err[3];
  logic [15:0]   op_count[3];

  int total = 0;
  int bad = 0;
  logic [FW-1:0] exp_q[$];

  noc_add_pe dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_flit(in_flit[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_flit(out_flit[0]),
    .out_ready(out_ready[0]), .busy(busy[0]), .carry_err(carry_err[0]),
    .dup_err(dup_err[0]), .op_count(op_count[0])
  );

  noc_add_pe #(.MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_flit(in_flit[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_flit(out_flit[1]),
    .out_ready(out_ready[1]), .busy(busy[1]), .carry_err(carry_err[1]),
    .dup_err(dup_err[1]), .op_count(op_count[1])
  );

  noc_add_pe #(.NUM_DEST(1), .DEST_LIST(4'd3), .VC_LIST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_flit(in_flit[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_flit(out_flit[2]),
    .out_ready(out_ready[2]), .busy(busy[2]), .carry_err(carry_err[2]),
    .dup_err(dup_err[2]), .op_count(op_count[2])
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected flit for send index k: default table is dest 3/5/1, vc 0/1/1.
  function automatic logic [FW-1:0] exp_flit(input int s, input int k, input logic [63:0] d);
    logic [3:0] dest;
    logic       vc;
    logic       tail;
    if (s == 2) begin
      dest = 4'd3; vc = 1'b0; tail = 1'b1;
    end else begin
      case (k)
        0:       begin dest = 4'd3; vc = 1'b0; end
        1:       begin dest = 4'd5; vc = 1'b1; end
        default: begin dest = 4'd1; vc = 1'b1; end
      endcase
      tail = (k == 2);
    end
    return {1'b1, tail, dest, vc, d};
  endfunction

  task automatic drive(input int s, input bit head, input bit tag, input logic [63:0] d);
    int n = 0;
    in_flit[s]  = {head, 1'b0, 4'd0, tag, d};
    in_valid[s] = 1'b1;
    while (in_ready[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", FW'(1'b0), FW'(1'b1));
    @(negedge clk);
    in_valid[s] = 1'b0;
    in_flit[s]  = '0;
  endtask

  task automatic push_result(input int s, input logic [63:0] r);
    for (int k = 0; k < ((s == 2) ? 1 : 3); k++) exp_q.push_back(exp_flit(s, k, r));
  endtask

  task automatic op(input int s, input logic [63:0] a, input logic [63:0] b);
    drive(s, 1'b1, 1'b0, a);
    push_result(s, (s == 1) ? a - b : a + b);
    drive(s, 1'b1, 1'b1, b);
  endtask

  task automatic drain(input int s, input int cnt, input int stall_k, input int stall_n);
    int n;
    logic [FW-1:0] e;
    for (int k = 0; k < cnt; k++) begin
      n = 0;
      while (out_valid[s] !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("latency_d%0d_k%0d", s, k), FW'(n), FW'((k == 0) ? 2 : 0));
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", FW'(1'b1), FW'(1'b0));
        return;
      end
      e = exp_q.pop_front();
      if (k == stall_k) begin
        out_ready[s] = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk($sformatf("hold_flit_d%0d", s), out_flit[s], e);
          chk($sformatf("hold_in_ready_d%0d", s), FW'(in_ready[s]), FW'(1'b0));
        end
        out_ready[s] = 1'b1;
      end
      chk($sformatf("flit_d%0d_k%0d", s, k), out_flit[s], e);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0; in_valid[s] = 1'b0; in_flit[s] = '0; out_ready[s] = 1'b1;
    end
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_out_valid_d%0d", s), FW'(out_valid[s]), FW'(1'b0));
      chk($sformatf("rst_out_flit_d%0d", s), out_flit[s], '0);
      chk($sformatf("rst_busy_d%0d", s), FW'(busy[s]), FW'(1'b0));
      chk($sformatf("rst_errs_d%0d", s), FW'({carry_err[s], dup_err[s]}), FW'(2'b00));
      chk($sformatf("rst_op_count_d%0d", s), FW'(op_count[s]), FW'(16'd0));
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;

    // Basic add, full-rate output.
    op(0, 64'd10, 64'd3);
    drain(0, 3, -1, 0);
    chk("op1_count", FW'(op_count[0]), FW'(16'd1));
    chk("op1_idle_valid", FW'(out_valid[0]), FW'(1'b0));
    chk("op1_idle_flit", out_flit[0], '0);
    chk("op1_carry", FW'(carry_err[0]), FW'(1'b0));
    chk("op1_busy", FW'(busy[0]), FW'(1'b0));

    // Backpressure at send index 1.
    op(0, 64'd10, 64'd3);
    drain(0, 3, 1, 4);
    chk("bp_count", FW'(op_count[0]), FW'(16'd2));

    // Wrap sets carry_err, which must persist.
    op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    drain(0, 3, -1, 0);
    chk("wrap_carry", FW'(carry_err[0]), FW'(1'b1));
    op(0, 64'd10, 64'd3);
    drain(0, 3, -1, 0);
    chk("wrap_carry_sticky", FW'(carry_err[0]), FW'(1'b1));
    chk("wrap_count", FW'(op_count[0]), FW'(16'd4));
    chk("pre_dup_err", FW'(dup_err[0]), FW'(1'b0));

    // Headless flit ignored, then duplicate A overwrites.
    drive(0, 1'b0, 1'b1, 64'd100);
    chk("headless_busy", FW'(busy[0]), FW'(1'b0));
    drive(0, 1'b1, 1'b0, 64'd7);
    chk("dup_err_before", FW'(dup_err[0]), FW'(1'b0));
    drive(0, 1'b1, 1'b0, 64'd9);
    chk("dup_err_after", FW'(dup_err[0]), FW'(1'b1));
    push_result(0, 64'd10);
    drive(0, 1'b1, 1'b1, 64'd1);
    drain(0, 3, -1, 0);
    chk("dup_count", FW'(op_count[0]), FW'(16'd5));

    // Subtract with borrow, reset after the first flit.
    op(1, 64'd3, 64'd10);
    drain(1, 1, -1, 0);
    chk("sub_carry", FW'(carry_err[1]), FW'(1'b1));
    chk("sub_mid_valid", FW'(out_valid[1]), FW'(1'b1));
    rst_n[1] = 1'b0;
    #1;
    chk("sub_rst_valid", FW'(out_valid[1]), FW'(1'b0));
    chk("sub_rst_flit", out_flit[1], '0);
    chk("sub_rst_count", FW'(op_count[1]), FW'(16'd0));
    chk("sub_rst_carry", FW'(carry_err[1]), FW'(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst_n[1] = 1'b1;
    op(1, 64'd20, 64'd5);
    drain(1, 3, -1, 0);
    chk("sub_after_count", FW'(op_count[1]), FW'(16'd1));
    chk("sub_after_carry", FW'(carry_err[1]), FW'(1'b0));

    // Single destination carries tail.
    op(2, 64'd5, 64'd6);
    drain(2, 1, -1, 0);
    chk("single_count", FW'(op_count[2]), FW'(16'd1));
    chk("single_idle_valid", FW'(out_valid[2]), FW'(1'b0));

    chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_add_pe.md
NOC_ADD_PE -- requirements
Module: noc_add_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width in bits.
REQ-002 SHALL have parameter DEST_W, default 4, destination field width.
REQ-003 SHALL have parameter NUM_DEST, default 3, range 1..8, number of result flits sent per operation.
REQ-004 SHALL have parameter DEST_LIST, default {4'd1,4'd5,4'd3} (index 0 in LSBs), NUM_DEST*DEST_W bits, destination per send index.
REQ-005 SHALL have parameter VC_LIST, default 3'b110 (index 0 in LSB), NUM_DEST bits, VC bit per send index.
REQ-006 SHALL have parameter MODE, default 0, 0 = A+B, 1 = A-B.
REQ-007 SHALL define FLIT_W = DATA_W+DEST_W+3; flit fields: [FLIT_W-1] head, [FLIT_W-2] tail, [FLIT_W-3:DATA_W+1] dest, [DATA_W] vc/tag, [DATA_W-1:0] data.
REQ-008 Ports, in order:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  input flit present.
  in_flit  in  FLIT_W  input flit.
  in_ready  out  1  PE accepts input flit this cycle.
  out_valid  out  1  output flit present.
  out_flit  out  FLIT_W  output flit.
  out_ready  in  1  downstream accepts output flit.
  busy  out  1  high in any state other than COLLECT.
  carry_err  out  1  sticky: an operation wrapped (carry out on add, borrow on sub).
  dup_err  out  1  sticky: operand tag received twice before compute.
  op_count  out  16  completed operations.

Function
REQ-009 SHALL implement states COLLECT, COMPUTE, SEND.
REQ-010 in_ready SHALL be 1 only in COLLECT; input accepted when in_valid & in_ready.
REQ-011 Accepted flit with head bit 0 SHALL be discarded, no state change.
REQ-012 Accepted flit tag bit [DATA_W]=0 SHALL load operand A, =1 SHALL load operand B, setting have_a/have_b.
REQ-013 Accepted operand whose have flag is already set SHALL overwrite it and set dup_err.
REQ-014 COLLECT->COMPUTE on the clock edge where, after that edge's load, have_a & have_b are both set.
REQ-015 COMPUTE SHALL last exactly one cycle, register result = A+B (MODE 0) or A-B (MODE 1) modulo 2^DATA_W, set carry_err on carry/borrow, then go to SEND with send index 0.
REQ-016 Latency: operand-completing acceptance at edge N -> out_valid high after edge N+2.
REQ-017 In SEND, out_valid SHALL be 1 and out_flit = {1, last, DEST_LIST[idx], VC_LIST[idx], result}, last=1 only when idx=NUM_DEST-1.
REQ-018 out_flit and out_valid SHALL be registered and SHALL stay stable while out_valid & !out_ready.
REQ-019 Each out_valid & out_ready edge SHALL advance idx by 1; on handshake at idx=NUM_DEST-1 SHALL clear have_a/have_b, increment op_count (wrapping 0xFFFF->0), return to COLLECT with out_valid=0 next cycle.
REQ-020 With NUM_DEST=1 the single flit SHALL carry tail=1.
REQ-021 No input SHALL be accepted during COMPUTE or SEND; upstream holds flits.
REQ-022 out_flit SHALL read all-zero whenever out_valid=0.

Reset
REQ-023 rst_n low SHALL immediately force state COLLECT, in_ready=1 (after release), out_valid=0, out_flit=0, busy=0, carry_err=0, dup_err=0, op_count=0, have_a=have_b=0, idx=0, operands/result=0.
REQ-024 Reset asserted mid-SEND SHALL abandon remaining flits; none resent after release.
REQ-025 First acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-026 Defaults, out_ready=1: A=10 (tag0), B=3 (tag1) -> flits data 13 with dest 3/vc0/tail0, dest 5/vc1/tail0, dest 1/vc1/tail1 on consecutive cycles; op_count=1.
REQ-027 Backpressure: out_ready low 4 cycles at idx 1 -> out_flit dest 5 held unchanged; in_ready=0 throughout; sequence completes after release.
REQ-028 Wrap: A=2^64-1, B=1 -> data 0, carry_err=1 and remains 1 across a following 10+3 operation.
REQ-029 Duplicate: A=7, A=9, B=1 -> dup_err=1, result 10; head-bit-0 flit with tag1 ignored beforehand.
REQ-030 MODE=1: A=3, B=10 -> data 2^64-7, carry_err=1; reset asserted after first flit -> out_valid=0 immediately, op_count=0, next op sends from idx 0.
